// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared widths, instruction field positions and helpers
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int PC_W     = 12;
  localparam int INSN_W   = 32;
  localparam int FIELD_W  = 5;
  localparam int IMM_W    = 17;
  localparam int TARGET_W = 27;

  // Least-significant bit of each 5-bit field within the instruction word
  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int SHAMT_LSB  = 7;
  localparam int ALUOP_LSB  = 2;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  localparam logic [INSN_W-1:0] NOP = 32'h0;

  function automatic logic [INSN_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(INSN_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if : imem port, control inputs and decode-slot outputs
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]     address_imem;
  logic [INSN_W-1:0]   q_imem;
  logic                stall;
  logic                redirect;
  logic [PC_W-1:0]     redirect_pc;
  logic                insn_valid;
  logic [INSN_W-1:0]   insn;
  logic [PC_W-1:0]     insn_pc;
  logic [FIELD_W-1:0]  opcode;
  logic [FIELD_W-1:0]  rd;
  logic [FIELD_W-1:0]  rs;
  logic [FIELD_W-1:0]  rt;
  logic [FIELD_W-1:0]  shamt;
  logic [FIELD_W-1:0]  aluop;
  logic [INSN_W-1:0]   imm_sext;
  logic [TARGET_W-1:0] target;

  modport master (
    input  q_imem, stall, redirect, redirect_pc,
    output address_imem, insn_valid, insn, insn_pc,
           opcode, rd, rs, rt, shamt, aluop, imm_sext, target
  );

  modport slave (
    output q_imem, stall, redirect, redirect_pc,
    input  address_imem, insn_valid, insn, insn_pc,
           opcode, rd, rs, rt, shamt, aluop, imm_sext, target
  );

endinterface

`default_nettype wire

// File: rtl/fetch_stage_fields.sv
// ---------------------------------------------------------------------------
// insn_fields : combinational field split and immediate sign extension
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module insn_fields
  import fetch_pkg::*;
(
  input  wire logic [INSN_W-1:0]   insn,
  output logic      [FIELD_W-1:0]  opcode,
  output logic      [FIELD_W-1:0]  rd,
  output logic      [FIELD_W-1:0]  rs,
  output logic      [FIELD_W-1:0]  rt,
  output logic      [FIELD_W-1:0]  shamt,
  output logic      [FIELD_W-1:0]  aluop,
  output logic      [INSN_W-1:0]   imm_sext,
  output logic      [TARGET_W-1:0] target
);

  assign opcode   = insn[OPCODE_LSB +: FIELD_W];
  assign rd       = insn[RD_LSB     +: FIELD_W];
  assign rs       = insn[RS_LSB     +: FIELD_W];
  assign rt       = insn[RT_LSB     +: FIELD_W];
  assign shamt    = insn[SHAMT_LSB  +: FIELD_W];
  assign aluop    = insn[ALUOP_LSB  +: FIELD_W];
  assign imm_sext = sext_imm(insn[IMM_LSB +: IMM_W]);
  assign target   = insn[TARGET_LSB +: TARGET_W];

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : single-issue fetch with stall hold register and redirect
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
(
  input  wire logic      clock,
  input  wire logic      reset,
  fetch_stage_if.master  bus
);

  // Bit 0 is the live flag, bit 1 the hold flag
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_LIVE  = 2'b01;
  localparam logic [1:0] ST_HELD  = 2'b11;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   fetch_pc_nxt;
  logic [PC_W-1:0]   insn_pc_r;
  logic [PC_W-1:0]   insn_pc_nxt;
  logic [INSN_W-1:0] hold_r;
  logic [INSN_W-1:0] hold_nxt;
  logic              live;
  logic [INSN_W-1:0] insn_cur;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_EMPTY;
      fetch_pc  <= '0;
      insn_pc_r <= '0;
      hold_r    <= NOP;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      insn_pc_r <= insn_pc_nxt;
      hold_r    <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    insn_pc_nxt  = insn_pc_r;
    hold_nxt     = hold_r;
    if (bus.redirect) begin
      state_nxt    = ST_EMPTY;
      fetch_pc_nxt = bus.redirect_pc;
    end else if (bus.stall) begin
      // Freeze a live imem word before the address moves on; held and empty slots just wait
      case (state)
        ST_LIVE: begin
          state_nxt = ST_HELD;
          hold_nxt  = bus.q_imem;
        end
        ST_HELD: state_nxt = ST_HELD;
        default: state_nxt = ST_EMPTY;
      endcase
    end else begin
      state_nxt    = ST_LIVE;
      fetch_pc_nxt = fetch_pc + 1'b1;
      insn_pc_nxt  = fetch_pc;
    end
  end

  always_comb begin
    live     = 1'b0;
    insn_cur = NOP;
    case (state)
      ST_LIVE: begin
        live     = 1'b1;
        insn_cur = bus.q_imem;
      end
      ST_HELD: begin
        live     = 1'b1;
        insn_cur = hold_r;
      end
      default: begin
        live     = 1'b0;
        insn_cur = NOP;
      end
    endcase
  end

  assign bus.address_imem = fetch_pc;
  assign bus.insn_valid   = live;
  assign bus.insn         = insn_cur;
  assign bus.insn_pc      = insn_pc_r;

  insn_fields u_fields (
    .insn     (insn_cur),
    .opcode   (bus.opcode),
    .rd       (bus.rd),
    .rs       (bus.rs),
    .rt       (bus.rt),
    .shamt    (bus.shamt),
    .aluop    (bus.aluop),
    .imm_sext (bus.imm_sext),
    .target   (bus.target)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed vector table, corner sequences, random vs model
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem [0:4095];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered imem: data this cycle is mem at last cycle's address
  always @(posedge clock) bus.q_imem <= mem[bus.address_imem];

  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [11:0] rpc;
    logic        ev;
    logic [11:0] epc;
    logic [31:0] einsn;
    logic [11:0] eaddr;
  } vec_t;

  vec_t vecs [40];
  int   nvec;

  task automatic add(input logic rst, input logic st, input logic rd, input logic [11:0] rpc,
                     input logic ev, input logic [11:0] epc, input logic [31:0] einsn,
                     input logic [11:0] eaddr);
    vecs[nvec] = '{rst, st, rd, rpc, ev, epc, einsn, eaddr};
    nvec++;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [11:0] epc,
                           input logic [31:0] ein, input logic [11:0] eaddr);
    logic [31:0] ei;
    ei = ev ? ein : 32'h0;
    cmp({tag, " insn_valid"}, {31'b0, bus.insn_valid}, {31'b0, ev});
    cmp({tag, " address_imem"}, {20'b0, bus.address_imem}, {20'b0, eaddr});
    cmp({tag, " insn"}, bus.insn, ei);
    if (ev) cmp({tag, " insn_pc"}, {20'b0, bus.insn_pc}, {20'b0, epc});
    cmp({tag, " opcode"}, {27'b0, bus.opcode}, {27'b0, ei[31:27]});
    cmp({tag, " rd"},     {27'b0, bus.rd},     {27'b0, ei[26:22]});
    cmp({tag, " rs"},     {27'b0, bus.rs},     {27'b0, ei[21:17]});
    cmp({tag, " rt"},     {27'b0, bus.rt},     {27'b0, ei[16:12]});
    cmp({tag, " shamt"},  {27'b0, bus.shamt},  {27'b0, ei[11:7]});
    cmp({tag, " aluop"},  {27'b0, bus.aluop},  {27'b0, ei[6:2]});
    cmp({tag, " imm_sext"}, bus.imm_sext, {{15{ei[16]}}, ei[16:0]});
    cmp({tag, " target"}, {5'b0, bus.target}, {5'b0, ei[26:0]});
  endtask

  task automatic step(input logic rst, input logic st, input logic rd, input logic [11:0] rpc);
    @(negedge clock);
    reset           = rst;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(posedge clock);
    #1;
  endtask

  // Sequence-level reference: what decode should show, and the next fetch address
  logic        m_valid;
  logic [11:0] m_pc;
  logic [31:0] m_insn;
  logic [11:0] m_next;

  initial begin
    checks          = 0;
    errors          = 0;
    nvec            = 0;
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    for (int k = 0; k < 4096; k++) mem[k] = k + 32'h100;

    //   rst st rd rpc      ev pc      insn        addr
    add(1, 0, 0, 12'h000, 0, 12'h000, 32'h0,   12'h000);
    add(1, 1, 1, 12'h123, 0, 12'h000, 32'h0,   12'h000);
    add(0, 0, 0, 12'h000, 1, 12'h000, 32'h100, 12'h001);
    add(0, 0, 0, 12'h000, 1, 12'h001, 32'h101, 12'h002);
    add(0, 0, 0, 12'h000, 1, 12'h002, 32'h102, 12'h003);
    add(0, 0, 0, 12'h000, 1, 12'h003, 32'h103, 12'h004);
    add(0, 0, 0, 12'h000, 1, 12'h004, 32'h104, 12'h005);
    add(0, 0, 0, 12'h000, 1, 12'h005, 32'h105, 12'h006);
    add(0, 1, 0, 12'h000, 1, 12'h005, 32'h105, 12'h006);
    add(0, 1, 0, 12'h000, 1, 12'h005, 32'h105, 12'h006);
    add(0, 1, 0, 12'h000, 1, 12'h005, 32'h105, 12'h006);
    add(0, 0, 0, 12'h000, 1, 12'h006, 32'h106, 12'h007);
    add(0, 0, 0, 12'h000, 1, 12'h007, 32'h107, 12'h008);
    add(0, 0, 0, 12'h000, 1, 12'h008, 32'h108, 12'h009);
    add(0, 0, 0, 12'h000, 1, 12'h009, 32'h109, 12'h00A);
    add(0, 0, 1, 12'h200, 0, 12'h000, 32'h0,   12'h200);
    add(0, 0, 0, 12'h000, 1, 12'h200, 32'h300, 12'h201);
    add(0, 1, 0, 12'h000, 1, 12'h200, 32'h300, 12'h201);
    add(0, 1, 1, 12'h010, 0, 12'h000, 32'h0,   12'h010);
    add(0, 0, 0, 12'h000, 1, 12'h010, 32'h110, 12'h011);
    add(0, 0, 1, 12'h040, 0, 12'h000, 32'h0,   12'h040);
    add(0, 1, 0, 12'h000, 0, 12'h000, 32'h0,   12'h040);
    add(0, 0, 0, 12'h000, 1, 12'h040, 32'h140, 12'h041);
    add(0, 1, 0, 12'h000, 1, 12'h040, 32'h140, 12'h041);
    add(1, 1, 0, 12'h000, 0, 12'h000, 32'h0,   12'h000);
    add(0, 0, 0, 12'h000, 1, 12'h000, 32'h100, 12'h001);
    add(0, 0, 0, 12'h000, 1, 12'h001, 32'h101, 12'h002);

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].rd, vecs[i].rpc);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einsn, vecs[i].eaddr);
    end

    // PC wrap and immediate sign extension at both polarities
    mem[4095] = 32'h0ABC_DEF0;
    mem[0]    = 32'h0001_FFFF;
    mem[1]    = 32'h0000_FFFF;
    step(0, 0, 1, 12'hFFF);
    check_out("wrap_bubble", 0, 12'h000, 32'h0, 12'hFFF);
    step(0, 0, 0, 12'h000);
    check_out("wrap_4095", 1, 12'hFFF, 32'h0ABC_DEF0, 12'h000);
    step(0, 0, 0, 12'h000);
    check_out("wrap_0", 1, 12'h000, 32'h0001_FFFF, 12'h001);
    cmp("imm_neg", bus.imm_sext, 32'hFFFF_FFFF);
    step(0, 0, 0, 12'h000);
    check_out("wrap_1", 1, 12'h001, 32'h0000_FFFF, 12'h002);
    cmp("imm_pos", bus.imm_sext, 32'h0000_FFFF);

    // Randomized run against the reference model
    for (int k = 0; k < 4096; k++) mem[k] = $urandom;
    m_valid = 1'b0;
    m_pc    = '0;
    m_insn  = '0;
    m_next  = '0;
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst;
      logic        r_st;
      logic        r_rd;
      logic [11:0] r_pc;
      r_rst = (c < 2) || ($urandom_range(0, 99) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 9) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? 12'(4090 + $urandom_range(0, 5))
                                          : 12'($urandom_range(0, 4095));
      step(r_rst, r_st, r_rd, r_pc);
      if (r_rst) begin
        m_valid = 1'b0;
        m_next  = '0;
      end else if (r_rd) begin
        m_valid = 1'b0;
        m_next  = r_pc;
      end else if (!r_st) begin
        m_valid = 1'b1;
        m_pc    = m_next;
        m_insn  = mem[m_next];
        m_next  = m_next + 12'd1;
      end
      check_out($sformatf("rand%0d", c), m_valid, m_pc, m_insn, m_next);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clock  input  1  single rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 q_imem  input  32  imem read data, 1-cycle registered latency: data at cycle t+1 = mem[address_imem at t].
REQ-004 stall  input  1  downstream cannot accept; hold current decode instruction.
REQ-005 redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-006 redirect_pc  input  12  redirect target word address.
REQ-007 address_imem  output  12  current fetch PC (F), driven directly from the PC register.
REQ-008 insn_valid  output  1  insn and its fields are live this cycle.
REQ-009 insn  output  32  decode-stage instruction; 32'h0 when insn_valid=0.
REQ-010 insn_pc  output  12  word address of insn.
REQ-011 opcode, rd, rs, rt, shamt, aluop  output  5 each  insn[31:27], [26:22], [21:17], [16:12], [11:7], [6:2].
REQ-012 imm_sext  output  32  insn[16:0] sign-extended from bit 16.
REQ-013 target  output  27  insn[26:0], zero-extended by consumer.

Function
REQ-014 Internal state SHALL be: F (12b), insn_pc register P (12b), live flag L, hold flag H, hold register R (32b); states EMPTY (L=0), LIVE (L=1,H=0), HELD (L=1,H=1).
REQ-015 insn SHALL be R when H=1, q_imem when L=1 and H=0, 32'h0 when L=0; insn_valid SHALL equal L.
REQ-016 All field outputs SHALL be combinational slices of insn, so an invalid slot decodes to opcode 00000 with all fields zero.
REQ-017 Normal cycle (redirect=0, stall=0): F<=F+1, P<=F, L<=1, H<=0.
REQ-018 Stall cycle (redirect=0, stall=1): F and P hold, L holds; if H=0 and L=1, R<=q_imem and H<=1; if H=1, R holds.
REQ-019 Stall with L=0 SHALL hold F and remain EMPTY; no capture.
REQ-020 On stall release, decode SHALL present mem[F] from q_imem the following cycle, because address F was presented throughout the stall.
REQ-021 Redirect cycle: F<=redirect_pc, L<=0, H<=0; exactly one bubble, then the instruction at redirect_pc with insn_pc=redirect_pc.
REQ-022 Redirect SHALL take priority over stall when both are asserted.
REQ-023 A redirect during HELD SHALL discard R.
REQ-024 F SHALL wrap modulo 4096 (4095+1 -> 0) with no flag.
REQ-025 Latency SHALL be one cycle from address_imem=A to insn_valid with insn_pc=A, absent stall and redirect.

Reset
REQ-026 While reset=1: F=0, P=0, L=0, H=0, R=0; address_imem=0, insn_valid=0, and insn and all fields read zero.
REQ-027 Reset SHALL override redirect and stall; the first valid instruction (pc 0) SHALL appear two edges after reset deasserts.

Structure
REQ-028 Package fetch_pkg SHALL hold PC_W=12, INSN_W=32, field bit-position constants, IMM_W=17, and NOP=32'h0.
REQ-029 Field splitting and sign-extension SHALL live in one combinational sub-module, insn_fields, instantiated once.

Verification
REQ-030 Reset, then free-run with mem[k]=k+32'h100 -> insn_valid rises 2nd edge after reset; insn_pc 0,1,2... with insn 0x100,0x101,...
REQ-031 Stall 3 cycles while insn_pc=5 -> insn stays mem[5], address_imem stays 6; after release insn_pc=6, then 7.
REQ-032 redirect=1, redirect_pc=0x200 at insn_pc=9 -> next cycle insn_valid=0 and insn=0; following cycle insn_pc=0x200.
REQ-033 redirect and stall together while HELD -> redirect wins; one bubble, then target; hold contents never reappear.
REQ-034 F=4095 free-run -> insn_pc 4095 then 0; mem[0]=0x0001_FFFF gives imm_sext=0xFFFF_FFFF; 0x0000_FFFF gives 0x0000_FFFF.
REQ-035 reset asserted mid-stall -> all outputs zero next edge; restart from pc 0.
